timer_bus_arbiter: RTL and testbench



---
 rtl/tmr_pkg.sv | 19 +
 rtl/tmr_rr_pick.sv | 21 ++
 rtl/timer_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_timer_bus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared definitions for the timer bus arbiter: default widths, timer register
// map and the access FSM state encoding.
package tmr_pkg;

  localparam int TMR_ADDR_W = 4;
  localparam int TMR_DATA_W = 32;

  localparam logic [TMR_ADDR_W-1:0] TMR_CTRL   = 4'h0;
  localparam logic [TMR_ADDR_W-1:0] TMR_LOAD   = 4'h4;
  localparam logic [TMR_ADDR_W-1:0] TMR_COUNT  = 4'h8;
  localparam logic [TMR_ADDR_W-1:0] TMR_STATUS = 4'hC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tmr_rr_pick.sv
// Combinational 2-way round-robin picker; lock_mask removes requesters that
// may not be considered this cycle.
module tmr_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic [1:0] lock_mask,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic [1:0] eligible;

  always_comb begin
    eligible  = req & lock_mask;
    gnt_valid = |eligible;
    // On a tie the requester that did not win last time goes first.
    if (&eligible) gnt_idx = ~last_grant;
    else           gnt_idx = eligible[1];
  end

endmodule

// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter sharing the timer register bus between two masters, one
// access per IDLE->ACCESS->DONE pass. Define TMR_ARB_LOCK_EN for locked grants.
module timer_bus_arbiter
  import tmr_pkg::*;
#(
  parameter int ADDR_W = TMR_ADDR_W,
  parameter int DATA_W = TMR_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef TMR_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic [ADDR_W-1:0] t_addr,
  output logic              t_wr_en,
  output logic              t_rd_en,
  output logic [DATA_W-1:0] t_wdata,
  input  logic [DATA_W-1:0] t_rdata
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] t_addr_q, t_addr_d;
  logic [DATA_W-1:0] t_wdata_q, t_wdata_d;
  logic              t_wr_en_q, t_wr_en_d;
  logic              t_rd_en_q, t_rd_en_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic [1:0]        req_vec, lock_mask;
  logic              pick_valid, pick_idx;

  assign req_vec = {m1_req, m0_req};

`ifdef TMR_ARB_LOCK_EN
  logic       lock_active_q, lock_active_d;
  logic       lock_idx_q, lock_idx_d;
  logic       lock_hold;
  logic [1:0] lock_vec;

  assign lock_vec  = {m1_lock, m0_lock};
  // The lock stays in force while its owner still shows interest.
  assign lock_hold = lock_active_q & (req_vec[lock_idx_q] | lock_vec[lock_idx_q]);
  assign lock_mask = !lock_hold ? 2'b11 : (lock_idx_q ? 2'b10 : 2'b01);
`else
  assign lock_mask = 2'b11;
`endif

  tmr_rr_pick u_pick (
    .req        (req_vec),
    .last_grant (last_grant_q),
    .lock_mask  (lock_mask),
    .gnt_valid  (pick_valid),
    .gnt_idx    (pick_idx)
  );

  always_comb begin
    // NOTE: every _d signal gets a default first, so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    t_addr_d     = t_addr_q;
    t_wdata_d    = t_wdata_q;
    t_wr_en_d    = 1'b0;
    t_rd_en_d    = 1'b0;
    ack_d        = 2'b00;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
`ifdef TMR_ARB_LOCK_EN
    lock_active_d = lock_active_q;
    lock_idx_d    = lock_idx_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef TMR_ARB_LOCK_EN
        if (!lock_hold) lock_active_d = 1'b0;
`endif
        if (pick_valid) begin
          state_d      = ACCESS;
          gnt_d        = pick_idx;
          last_grant_d = pick_idx;
          t_addr_d     = pick_idx ? m1_addr  : m0_addr;
          t_wdata_d    = pick_idx ? m1_wdata : m0_wdata;
          t_wr_en_d    = pick_idx ? m1_we    : m0_we;
          t_rd_en_d    = ~t_wr_en_d;
        end
      end
      ACCESS: begin
        state_d = DONE;
        ack_d   = gnt_q ? 2'b10 : 2'b01;
        if (t_rd_en_q) begin
          if (gnt_q) m1_rdata_d = t_rdata;
          else       m0_rdata_d = t_rdata;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef TMR_ARB_LOCK_EN
        lock_active_d = lock_vec[gnt_q];
        lock_idx_d    = gnt_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      t_addr_q     <= '0;
      t_wdata_q    <= '0;
      t_wr_en_q    <= 1'b0;
      t_rd_en_q    <= 1'b0;
      ack_q        <= 2'b00;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      t_addr_q     <= t_addr_d;
      t_wdata_q    <= t_wdata_d;
      t_wr_en_q    <= t_wr_en_d;
      t_rd_en_q    <= t_rd_en_d;
      ack_q        <= ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

`ifdef TMR_ARB_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_active_q <= 1'b0;
      lock_idx_q    <= 1'b0;
    end else begin
      lock_active_q <= lock_active_d;
      lock_idx_q    <= lock_idx_d;
    end
  end
`endif

  assign t_addr   = t_addr_q;
  assign t_wdata  = t_wdata_q;
  assign t_wr_en  = t_wr_en_q;
  assign t_rd_en  = t_rd_en_q;
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Self-checking bench for timer_bus_arbiter: directed scenarios plus random
// traffic against a cycle-timed transaction model. Honours TMR_ARB_LOCK_EN.
module tb_timer_bus_arbiter;
  import tmr_pkg::*;

  localparam int AW = TMR_ADDR_W;
  localparam int DW = TMR_DATA_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_req  [2];
  logic          m_we   [2];
  logic          m_lock [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata[2];
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] t_addr;
  logic          t_wr_en, t_rd_en;
  logic [DW-1:0] t_wdata, t_rdata;

  timer_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m_req[0]),
    .m0_we    (m_we[0]),
    .m0_addr  (m_addr[0]),
    .m0_wdata (m_wdata[0]),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (m_req[1]),
    .m1_we    (m_we[1]),
    .m1_addr  (m_addr[1]),
    .m1_wdata (m_wdata[1]),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
`ifdef TMR_ARB_LOCK_EN
    .m0_lock  (m_lock[0]),
    .m1_lock  (m_lock[1]),
`endif
    .t_addr   (t_addr),
    .t_wr_en  (t_wr_en),
    .t_rd_en  (t_rd_en),
    .t_wdata  (t_wdata),
    .t_rdata  (t_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: an access granted at the end of cycle c strobes
  // in c+1, acks in c+2, and the bus is free to arbitrate again from c+3.
  int            cyc;
  int            free_at, strobe_at, ack_at;
  bit            win, last_g, win_we;
  logic [AW-1:0] win_addr, exp_taddr;
  logic [DW-1:0] win_wdata, exp_twdata;
  logic [DW-1:0] exp_rdata[2];
  bit            lock_act, lock_own;
  bit            fix_rdata;
  logic [DW-1:0] fixed_rdata;
  int            ack_log_idx[$];
  int            ack_log_cyc[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    free_at      = 0;
    strobe_at    = -10;
    ack_at       = -10;
    last_g       = 1'b1;
    exp_taddr    = '0;
    exp_twdata   = '0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    lock_act     = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".t_wr_en"},  DW'(t_wr_en),  DW'(strobe_at == cyc && win_we));
    check({tag, ".t_rd_en"},  DW'(t_rd_en),  DW'(strobe_at == cyc && !win_we));
    check({tag, ".t_addr"},   DW'(t_addr),   DW'(exp_taddr));
    check({tag, ".t_wdata"},  t_wdata,       exp_twdata);
    check({tag, ".m0_ack"},   DW'(m0_ack),   DW'(ack_at == cyc && !win));
    check({tag, ".m1_ack"},   DW'(m1_ack),   DW'(ack_at == cyc && win));
    check({tag, ".m0_rdata"}, m0_rdata,      exp_rdata[0]);
    check({tag, ".m1_rdata"}, m1_rdata,      exp_rdata[1]);
  endtask

  // One clock cycle: apply model consequences of the current inputs, advance
  // to the next mid-cycle point, compare every output, then refresh t_rdata.
  task automatic tick();
    logic [1:0] pend;
    if (strobe_at == cyc && !win_we) exp_rdata[win] = t_rdata;
`ifdef TMR_ARB_LOCK_EN
    if (ack_at == cyc) begin
      lock_act = m_lock[win];
      lock_own = win;
    end
`endif
    if (cyc >= free_at) begin
      pend = {m_req[1], m_req[0]};
`ifdef TMR_ARB_LOCK_EN
      if (lock_act && !m_req[lock_own] && !m_lock[lock_own]) lock_act = 1'b0;
      if (lock_act) pend[~lock_own] = 1'b0;
`endif
      if (pend != 2'b00) begin
        win       = (pend == 2'b11) ? !last_g : pend[1];
        last_g    = win;
        win_we    = m_we[win];
        win_addr  = m_addr[win];
        win_wdata = m_wdata[win];
        strobe_at = cyc + 1;
        ack_at    = cyc + 2;
        free_at   = cyc + 3;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (strobe_at == cyc) begin
      exp_taddr  = win_addr;
      exp_twdata = win_wdata;
    end
    check_outputs("cycle");
    if (m0_ack === 1'b1) begin ack_log_idx.push_back(0); ack_log_cyc.push_back(cyc); end
    if (m1_ack === 1'b1) begin ack_log_idx.push_back(1); ack_log_cyc.push_back(cyc); end
    t_rdata = fix_rdata ? fixed_rdata : $urandom();
  endtask

  task automatic new_random(input int m);
    m_we[m]    = 1'($urandom_range(0, 1));
    m_addr[m]  = AW'($urandom_range(0, 15));
    m_wdata[m] = $urandom();
    m_req[m]   = 1'b1;
  endtask

  task automatic service(input bit keep_busy, input bit rnd);
    for (int m = 0; m < 2; m++) begin
      if (ack_at == cyc && int'(win) == m) begin
        m_req[m]  = 1'b0;
        m_lock[m] = 1'b0;
        if (keep_busy) new_random(m);
      end
      if (rnd && m_req[m] == 1'b0 && $urandom_range(0, 2) == 0) new_random(m);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      service(1'b0, 1'b0);
    end
  endtask

  task automatic run_until_acks(input int target, input int budget, input bit keep_busy);
    int n = 0;
    while (ack_log_idx.size() < target && n < budget) begin
      tick();
      service(keep_busy, 1'b0);
      n++;
    end
    if (ack_log_idx.size() < target)
      check("ack_timeout", DW'(ack_log_idx.size()), DW'(target));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_req[0] || m_req[1]) && n < budget) begin
      tick();
      service(1'b0, 1'b0);
      n++;
    end
    if (m_req[0] || m_req[1]) check("drain_timeout", DW'(ack_log_idx.size()), DW'(n + 1000));
    idle(2);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      m_req[m]  = 1'b0;
      m_lock[m] = 1'b0;
    end
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs("reset_hold");
    rst = 1'b0;
  endtask

  initial begin
    int start;
    cyc         = 0;
    fix_rdata   = 1'b0;
    fixed_rdata = '0;
    t_rdata     = '0;
    rst         = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_req[m] = 1'b0; m_we[m] = 1'b0; m_lock[m] = 1'b0;
      m_addr[m] = '0; m_wdata[m] = '0;
    end
    model_reset();
    #2;
    apply_reset();
    idle(2);

    // Lone m0 write to CTRL.
    ack_log_idx.delete(); ack_log_cyc.delete();
    start = cyc;
    m_we[0] = 1'b1; m_addr[0] = TMR_CTRL; m_wdata[0] = 32'h0000_0003; m_req[0] = 1'b1;
    run_until_acks(1, 8, 1'b0);
    if (ack_log_idx.size() >= 1) begin
      check("w0_idx", DW'(ack_log_idx[0]), DW'(0));
      check("w0_lat", DW'(ack_log_cyc[0] - start), DW'(2));
    end
    check("w0_t_addr_held", DW'(t_addr), DW'(TMR_CTRL));
    check("w0_t_wdata_held", t_wdata, 32'h0000_0003);
    idle(2);

    // Lone m1 read of COUNT with a fixed register value.
    ack_log_idx.delete(); ack_log_cyc.delete();
    fix_rdata = 1'b1; fixed_rdata = 32'h1234_5678; t_rdata = fixed_rdata;
    start = cyc;
    m_we[1] = 1'b0; m_addr[1] = TMR_COUNT; m_req[1] = 1'b1;
    run_until_acks(1, 8, 1'b0);
    if (ack_log_idx.size() >= 1) begin
      check("r1_idx", DW'(ack_log_idx[0]), DW'(1));
      check("r1_lat", DW'(ack_log_cyc[0] - start), DW'(2));
    end
    check("r1_m1_rdata", m1_rdata, 32'h1234_5678);
    check("r1_m0_rdata", m0_rdata, 32'h0);
    fix_rdata = 1'b0;
    idle(2);

    // Both masters requesting continuously: strict alternation, 3 cycles apart.
    ack_log_idx.delete(); ack_log_cyc.delete();
    new_random(0);
    new_random(1);
    run_until_acks(6, 40, 1'b1);
    for (int i = 0; i < 6 && i < ack_log_idx.size(); i++) begin
      check($sformatf("rr_order%0d", i), DW'(ack_log_idx[i]), DW'(i % 2));
      if (i > 0) check($sformatf("rr_gap%0d", i), DW'(ack_log_cyc[i] - ack_log_cyc[i-1]), DW'(3));
    end
    drain(20);

    // Reset asserted while a read strobe is on the bus.
    ack_log_idx.delete(); ack_log_cyc.delete();
    m_we[0] = 1'b0; m_addr[0] = TMR_LOAD; m_req[0] = 1'b1;
    tick();
    check("rst_pre_strobe", DW'(t_rd_en), DW'(1));
    apply_reset();
    idle(3);
    check("rst_no_ack", DW'(ack_log_idx.size()), DW'(0));

    // Write to an unmapped address still completes.
    ack_log_idx.delete(); ack_log_cyc.delete();
    start = cyc;
    m_we[1] = 1'b1; m_addr[1] = 4'h6; m_wdata[1] = $urandom(); m_req[1] = 1'b1;
    run_until_acks(1, 8, 1'b0);
    if (ack_log_idx.size() >= 1) begin
      check("undef_idx", DW'(ack_log_idx[0]), DW'(1));
      check("undef_lat", DW'(ack_log_cyc[0] - start), DW'(2));
    end
    idle(2);

`ifdef TMR_ARB_LOCK_EN
    // Locked read-modify-write by m0 while m1 waits.
    begin
      int n = 0;
      int phase = 0;
      apply_reset();
      idle(1);
      ack_log_idx.delete(); ack_log_cyc.delete();
      m_we[0] = 1'b0; m_addr[0] = TMR_CTRL; m_lock[0] = 1'b1; m_req[0] = 1'b1;
      m_we[1] = 1'b1; m_addr[1] = TMR_CTRL; m_wdata[1] = $urandom(); m_req[1] = 1'b1;
      while (ack_log_idx.size() < 3 && n < 30) begin
        tick();
        if (phase == 0 && ack_at == cyc && !win) begin
          phase = 1;
        end else if (phase == 1) begin
          m_we[0] = 1'b1; m_wdata[0] = $urandom(); m_lock[0] = 1'b0;
          phase = 2;
        end else if (ack_at == cyc) begin
          m_req[win]  = 1'b0;
          m_lock[win] = 1'b0;
        end
        n++;
      end
      check("lock_acks", DW'(ack_log_idx.size()), DW'(3));
      if (ack_log_idx.size() >= 3) begin
        check("lock_first",  DW'(ack_log_idx[0]), DW'(0));
        check("lock_second", DW'(ack_log_idx[1]), DW'(0));
        check("lock_third",  DW'(ack_log_idx[2]), DW'(1));
        check("lock_gap",    DW'(ack_log_cyc[1] - ack_log_cyc[0]), DW'(3));
      end
      drain(20);
    end
`endif

    // Random traffic from both masters.
    for (int i = 0; i < 400; i++) begin
      tick();
      service(1'b0, 1'b1);
    end
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
